// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: default widths and
// the fixed requester slots feeding the writeback arbiter.
package regfile_pkg;

  localparam int B_DEFAULT = 32;
  localparam int W_DEFAULT = 5;
  localparam int N_DEFAULT = 3;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
// The pointer moves only when the grant is actually taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  input  logic         stall,
  output logic [N-1:0] grant
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [LW-1:0] last_grant;
  logic [LW-1:0] grant_idx;
  logic          found;

  // Unroll over every pointer value so that all request indices are constants.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int l = 0; l < N; l++) begin
      if (last_grant == LW'(l)) begin
        for (int k = 1; k <= N; k++) begin
          if (!found && req[(l + k) % N]) begin
            grant[(l + k) % N] = 1'b1;
            found              = 1'b1;
          end
        end
      end
    end
    if (stall) grant = '0;
  end

  always_comb begin
    grant_idx = last_grant;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = LW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LW'(N - 1);
    end else if (advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file: picks one requester per cycle,
// registers the write, and tracks outstanding destinations in a busy scoreboard.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int B = B_DEFAULT,
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_addr,
  input  logic [N*B-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  input  logic            wb_stall,
  input  logic            iss_valid,
  input  logic [W-1:0]    iss_addr,
  output logic            wr_en,
  output logic [W-1:0]    w_addr,
  output logic [B-1:0]    w_data,
  output logic [2**W-1:0] busy
);

  // Handshake: requester i transfers on an edge where req_valid[i] && req_ready[i];
  // it holds valid, addr and data stable until then. req_ready depends on
  // req_valid, never the reverse.
  logic [N-1:0]    grant;
  logic            hs;
  logic [W-1:0]    sel_addr;
  logic [B-1:0]    sel_data;
  logic [2**W-1:0] busy_next;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (hs),
    .stall   (wb_stall | ~rst_n),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign hs        = |(req_valid & grant);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*W +: W];
        sel_data = req_data[i*B +: B];
      end
    end
  end

  // Address 0 is a sink: the request is consumed but nothing is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      wr_en <= hs && (sel_addr != '0);
      if (hs && (sel_addr != '0)) begin
        w_addr <= sel_addr;
        w_data <= sel_data;
      end
    end
  end

  // Set is applied after clear so a new issue to the same register wins.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[w_addr] = 1'b0;
    if (iss_valid && (iss_addr != '0)) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
